act_skew_feeder: RTL
====================

ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter ARRAY_ROW, default 12, rows of downstream systolic array.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per activation element.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  upstream beat valid.
REQ-006 SHALL have port s_ready  output  1  feeder accepts beat this cycle.
REQ-007 SHALL have port s_act_vec  input  ARRAY_ROW*DATA_WIDTH  one activation per row; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_last  input  1  marks final beat of sequence; qualified by s_valid.
REQ-009 SHALL have port out_act_vec  output  ARRAY_ROW*DATA_WIDTH  skewed activations, drives systolic in_act_vec.
REQ-010 SHALL have port out_en_compute  output  1  drives systolic en_compute.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when sequence fully skewed out.

Function
REQ-013 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-014 SHALL drive s_ready=1 in IDLE and STREAM, 0 in DRAIN and DONE; beat accepted when s_valid&s_ready.
REQ-015 SHALL transition IDLE->STREAM on accepted beat without s_last; IDLE/STREAM->DRAIN on accepted beat with s_last.
REQ-016 SHALL define advance = accepted beat, or state==DRAIN; no other cycle shifts the delay lines.
REQ-017 SHALL hold per row r a delay line of r+1 registers, shifting only on advance; input is s_act_vec row slice on accepted beat, zero in DRAIN.
REQ-018 SHALL drive out_act_vec row r from last register of row r line (registered output, no combinational path from s_act_vec).
REQ-019 SHALL produce latency: beat accepted at cycle T with no later stalls appears on row r during cycle T+1+r.
REQ-020 SHALL register out_en_compute as advance of previous cycle, so data and enable reach the array together.
REQ-021 SHALL, on STREAM cycle with s_valid=0 (bubble), freeze all delay lines and drive out_en_compute=0 next cycle; the array holds state while en_compute=0.
REQ-022 SHALL count ARRAY_ROW-1 DRAIN advances then enter DONE; for ARRAY_ROW=1, go directly to DONE.
REQ-023 SHALL assert done only in DONE (one cycle), then return to IDLE; delay lines are all zero at that point.
REQ-024 SHALL ignore s_valid/s_act_vec/s_last when s_ready=0.
REQ-025 SHALL output zero on any row slot not carrying an accepted beat (leading/trailing skew padding).

Reset
REQ-026 SHALL on rst=1 at a rising edge: state IDLE, all delay lines and drain counter zero, out_act_vec=0, out_en_compute=0, busy=0, done=0, s_ready=1 after the edge.
REQ-027 SHALL abort any STREAM/DRAIN on reset without emitting done.

Configuration
REQ-028 SHALL, when macro ACT_SKEW_STALL_CNT_EN is defined, add output stall_cnt (16 bits): counts STREAM cycles with s_valid=0, saturates at 16'hFFFF, clears on IDLE->STREAM/DRAIN transition and on reset, holds value otherwise.
REQ-029 SHALL, when ACT_SKEW_STALL_CNT_EN is undefined, omit stall_cnt port and its logic; all other behaviour identical.

Verification (ARRAY_ROW=12, DATA_WIDTH=8)
REQ-030 Reset: rst high 2 cycles mid-idle -> out_act_vec=0, out_en_compute=0, s_ready=1, busy=0, done=0.
REQ-031 Single beat rows 0x01..0x0C with s_last accepted at T -> row r = r+1 only at cycle T+1+r, else 0; out_en_compute high T+1..T+12; done high exactly at T+12; s_ready=0 T+1..T+12.
REQ-032 32 back-to-back beats, beat t row r = (t*12+r)&0xFF, s_last on t=31 -> row r carries beat t at cycle T0+1+t+r; out_en_compute continuously high 43 cycles; one done pulse.
REQ-033 Bubble: s_valid=0 for 3 cycles after beat 5 -> out_en_compute low 3 cycles, out_act_vec frozen, s_ready=1, later output equals stall-free sequence shifted by 3.
REQ-034 Reset during DRAIN (3rd drain cycle) -> next cycle all outputs zero, state IDLE, no done pulse; new sequence after works per REQ-031.
REQ-035 With ACT_SKEW_STALL_CNT_EN: REQ-033 stimulus -> stall_cnt=3 after done; next sequence start -> stall_cnt=0.

Source files
------------

// File: rtl/act_skew_feeder.sv
// act_skew_feeder: skews activation beats row-by-row into a systolic array; optional stall counter via ACT_SKEW_STALL_CNT_EN
module act_skew_feeder #(
    parameter int ARRAY_ROW  = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [ARRAY_ROW*DATA_WIDTH-1:0] s_act_vec,
    input  logic                            s_last,
    output logic [ARRAY_ROW*DATA_WIDTH-1:0] out_act_vec,
    output logic                            out_en_compute,
    output logic                            busy,
    output logic                            done
`ifdef ACT_SKEW_STALL_CNT_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int CW = ARRAY_ROW > 2 ? $clog2(ARRAY_ROW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ARRAY_ROW > 1 ? ARRAY_ROW - 2 : 0);
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;
    logic          accept, advance;
    assign s_ready        = (state_q == IDLE) || (state_q == STREAM);
    assign accept         = s_valid && s_ready;
    assign advance        = accept || (state_q == DRAIN);
    assign busy           = state_q != IDLE;
    assign done           = state_q == DONE;
    assign out_en_compute = en_q;
    // next state: last beat starts the drain, drain runs ARRAY_ROW-1 advances
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    state_d = s_last ? (ARRAY_ROW == 1 ? DONE : DRAIN) : STREAM;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_LAST) ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, drain counter and the enable that travels alongside the data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= advance;
        end
    end
    for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_row
        logic [DATA_WIDTH-1:0] line_q [r+1];
        logic [DATA_WIDTH-1:0] din_d;
        assign din_d = accept ? s_act_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign out_act_vec[r*DATA_WIDTH +: DATA_WIDTH] = line_q[r];
        // row r delay line of r+1 stages; flushed in DONE so idle output is zero
        always_ff @(posedge clk) begin
            if (rst || state_q == DONE) begin
                for (int k = 0; k <= r; k++) line_q[k] <= '0;
            end else if (advance) begin
                line_q[0] <= din_d;
                for (int k = 1; k <= r; k++) line_q[k] <= line_q[k-1];
            end
        end
    end
`ifdef ACT_SKEW_STALL_CNT_EN
    logic [15:0] stall_q;
    assign stall_cnt = stall_q;
    // saturating count of upstream bubbles within one sequence
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && accept))
            stall_q <= '0;
        else if (state_q == STREAM && !s_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
`endif
endmodule
